map_table: RTL and testbench
============================

MAP_TABLE -- requirements
Module: map_table

Interface
REQ-001 Parameter: ROB_LEN, default `ROB_LEN (8), number of ROB entries; tag width TW = $clog2(ROB_LEN).
REQ-002 Parameter: REG_LEN, default `REG_LEN (32), number of architectural registers; index width RW = $clog2(REG_LEN).
REQ-003 Port: clock  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: stall  input  1  pipeline stall; blocks dispatch and retire updates.
REQ-006 Port: dispatch_valid  input  1  an instruction is renamed this cycle.
REQ-007 Port: dispatch_dest_idx  input  RW  destination architectural register of the dispatching instruction.
REQ-008 Port: dispatch_tag  input  TW  ROB entry allocated to the dispatching instruction (ROB tail).
REQ-009 Port: rs1_idx, rs2_idx  input  RW each  source registers to look up.
REQ-010 Port: cdb_valid  input  1  CDB broadcast is valid.
REQ-011 Port: cdb_tag  input  TW  ROB tag being completed.
REQ-012 Port: retire_valid  input  1  ROB head retires this cycle.
REQ-013 Port: retire_tag  input  TW  ROB head index of the retiring instruction.
REQ-014 Port: retire_dest_idx  input  RW  destination register of the retiring instruction.
REQ-015 Port: squash  input  1  mispredict recovery; flush all mappings.
REQ-016 Port: rs1_busy, rs2_busy  output  1 each  source is mapped to an in-flight ROB entry.
REQ-017 Port: rs1_tag, rs2_tag  output  TW each  ROB tag of the source (0 when not busy).
REQ-018 Port: rs1_ready, rs2_ready  output  1 each  mapped ROB entry holds its value (read from ROB, not RF).
REQ-019 Port: busy_vec  output  REG_LEN  per-register busy bits, for debug.

Function
REQ-020 Per register r, state: busy, tag[TW], ready; register 0 SHALL never become busy.
REQ-021 Dispatch: if dispatch_valid && !stall && dispatch_dest_idx != 0, entry[dest] <= {busy=1, tag=dispatch_tag, ready=0} next cycle.
REQ-022 CDB: if cdb_valid, every entry with busy && tag == cdb_tag sets ready=1 next cycle; stall does not block CDB updates.
REQ-023 Retire: if retire_valid && !stall && entry[retire_dest_idx].busy && tag == retire_tag, busy, ready and tag clear next cycle; tag mismatch leaves entry unchanged (newer rename).
REQ-024 Same-register dispatch and retire in one cycle: dispatch wins; entry holds the new tag, busy=1, ready=0.
REQ-025 Dispatch write to an entry overrides a same-cycle CDB ready for that entry.
REQ-026 Squash: all entries cleared next cycle; overrides dispatch, CDB, retire and stall.
REQ-027 Lookup combinational, zero latency: rsN_busy/tag/ready from current state of entry[rsN_idx]; rsN_idx == 0 gives all zeros.
REQ-028 CDB forwarding: rsN_ready = 1 when busy and cdb_valid && cdb_tag == tag, same cycle.
REQ-029 Lookups SHALL NOT see same-cycle dispatch (sources read before rename), so rs1_idx == dispatch_dest_idx returns the old mapping.
REQ-030 rsN_tag SHALL be 0 whenever rsN_busy is 0.

Reset
REQ-031 On reset all busy, tag, ready clear; busy_vec = 0 and all rsN outputs = 0 from the cycle after reset.
REQ-032 Reset asserted mid-operation overrides squash, dispatch, CDB and retire in that cycle.

Structure
REQ-033 MT_ENTRY typedef {busy, tag, ready} and the MT2RS lookup packet typedef belong in the shared sys_defs package; `ROB_LEN/`REG_LEN/`ZERO_REG remain global macros.
REQ-034 One sub-module, map_table_entry, holds one register's state and next-state logic, instantiated REG_LEN-1 times (r1..r31); register 0 is tied off.

Verification
REQ-035 Reset, then lookup rs1=5, rs2=0 -> busy=0, tag=0, ready=0 on both.
REQ-036 Dispatch dest=5 tag=3; next cycle rs1=5 -> busy=1, tag=3, ready=0; CDB tag=3 -> same-cycle ready=1, held ready=1 next cycle.
REQ-037 Dispatch dest=5 tag=3, then dest=5 tag=4; retire tag=3 dest=5 -> entry stays busy tag=4; retire tag=4 -> busy=0.
REQ-038 Same cycle: retire tag=2 dest=7 and dispatch dest=7 tag=6 -> next cycle busy=1, tag=6, ready=0.
REQ-039 Fill r1..r4 with tags 1..4, assert squash together with dispatch dest=9 -> busy_vec = 0 next cycle.
REQ-040 stall=1 with dispatch dest=8 tag=1 and CDB tag=1 matching an existing r3 mapping -> r8 unchanged, r3 ready=1.

Source files
------------

// File: rtl/map_table_pkg.sv
// Shared definitions for the register map table (rename table).
// Holds the default table geometry and the entry / lookup packet types.
// No ports: imported by map_table and map_table_entry.
package map_table_pkg;

  localparam int MT_ROB_LEN_DEF = 8;   // default number of ROB entries
  localparam int MT_REG_LEN_DEF = 32;  // default number of architectural registers
  localparam int MT_ZERO_REG    = 0;   // hard-wired zero register, never renamed

  localparam int MT_TW_DEF = $clog2(MT_ROB_LEN_DEF);

  // State of one architectural register (default geometry).
  typedef struct packed {
    logic                 busy;
    logic [MT_TW_DEF-1:0] tag;
    logic                 ready;
  } mt_entry_t;

  // Lookup packet handed to a reservation station for one source operand.
  typedef struct packed {
    logic                 busy;
    logic [MT_TW_DEF-1:0] tag;
    logic                 ready;
  } mt2rs_t;

endpackage

// File: rtl/map_table_entry.sv
// One architectural register's rename state (busy, tag, ready) together
// with its next-state logic.
// Ports:
//   clock, reset            : clock and synchronous active-high reset
//   stall, squash           : stall blocks dispatch/retire; squash clears
//   dispatch_*              : rename of a destination register
//   cdb_valid, cdb_tag      : completion broadcast, sets ready on tag match
//   retire_*                : ROB head retirement, frees a matching mapping
//   busy, tag, ready        : current registered state of this register
module map_table_entry
  import map_table_pkg::*;
#(
  parameter int TW  = MT_TW_DEF,
  parameter int RW  = 5,
  parameter int IDX = 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          stall,
  input  logic          squash,
  input  logic          dispatch_valid,
  input  logic [RW-1:0] dispatch_dest_idx,
  input  logic [TW-1:0] dispatch_tag,
  input  logic          cdb_valid,
  input  logic [TW-1:0] cdb_tag,
  input  logic          retire_valid,
  input  logic [TW-1:0] retire_tag,
  input  logic [RW-1:0] retire_dest_idx,
  output logic          busy,
  output logic [TW-1:0] tag,
  output logic          ready
);

  localparam logic [RW-1:0] MY_IDX = RW'(IDX);

  logic          busy_q, busy_d;
  logic [TW-1:0] tag_q, tag_d;
  logic          ready_q, ready_d;

  // Priority, lowest to highest: CDB ready, retire clear, dispatch, squash.
  always_comb begin
    busy_d  = busy_q;
    tag_d   = tag_q;
    ready_d = ready_q;
    if (cdb_valid && busy_q && (tag_q == cdb_tag)) begin
      ready_d = 1'b1;
    end
    // A tag mismatch means the register has since been renamed again,
    // so the newer mapping must survive the older instruction's retire.
    if (retire_valid && !stall && (retire_dest_idx == MY_IDX) &&
        busy_q && (tag_q == retire_tag)) begin
      busy_d  = 1'b0;
      tag_d   = '0;
      ready_d = 1'b0;
    end
    if (dispatch_valid && !stall && (dispatch_dest_idx == MY_IDX)) begin
      busy_d  = 1'b1;
      tag_d   = dispatch_tag;
      ready_d = 1'b0;
    end
    if (squash) begin
      busy_d  = 1'b0;
      tag_d   = '0;
      ready_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      busy_q  <= 1'b0;
      tag_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      busy_q  <= busy_d;
      tag_q   <= tag_d;
      ready_q <= ready_d;
    end
  end

  assign busy  = busy_q;
  assign tag   = tag_q;
  assign ready = ready_q;

endmodule

// File: rtl/map_table.sv
// Register map table for a Tomasulo/ROB pipeline. Tracks, per architectural
// register, whether its newest value is owned by an in-flight ROB entry and
// whether that entry has produced its result.
// Ports:
//   clock, reset                     : clock, synchronous active-high reset
//   stall, squash                    : pipeline stall, mispredict flush
//   dispatch_valid/_dest_idx/_tag    : rename of a destination register
//   rs1_idx, rs2_idx                 : source registers looked up this cycle
//   cdb_valid, cdb_tag               : completion broadcast
//   retire_valid/_tag/_dest_idx      : ROB head retirement
//   rsN_busy/_tag/_ready             : combinational lookup results
//   busy_vec                         : per-register busy bits (debug view)
// Handshake: all *_valid inputs are single-cycle qualifiers with no ready
// back-pressure; an update is taken on the rising edge where valid is high
// (dispatch and retire additionally need stall low).
module map_table
  import map_table_pkg::*;
#(
  parameter int ROB_LEN = MT_ROB_LEN_DEF,
  parameter int REG_LEN = MT_REG_LEN_DEF
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        stall,
  input  logic                        dispatch_valid,
  input  logic [$clog2(REG_LEN)-1:0]  dispatch_dest_idx,
  input  logic [$clog2(ROB_LEN)-1:0]  dispatch_tag,
  input  logic [$clog2(REG_LEN)-1:0]  rs1_idx,
  input  logic [$clog2(REG_LEN)-1:0]  rs2_idx,
  input  logic                        cdb_valid,
  input  logic [$clog2(ROB_LEN)-1:0]  cdb_tag,
  input  logic                        retire_valid,
  input  logic [$clog2(ROB_LEN)-1:0]  retire_tag,
  input  logic [$clog2(REG_LEN)-1:0]  retire_dest_idx,
  input  logic                        squash,
  output logic                        rs1_busy,
  output logic                        rs2_busy,
  output logic [$clog2(ROB_LEN)-1:0]  rs1_tag,
  output logic [$clog2(ROB_LEN)-1:0]  rs2_tag,
  output logic                        rs1_ready,
  output logic                        rs2_ready,
  output logic [REG_LEN-1:0]          busy_vec
);

  localparam int TW = $clog2(ROB_LEN);
  localparam int RW = $clog2(REG_LEN);

  logic          e_busy  [REG_LEN];
  logic [TW-1:0] e_tag   [REG_LEN];
  logic          e_ready [REG_LEN];

  // The zero register is never renamed, so a lookup of it reads all zeros.
  assign e_busy[MT_ZERO_REG]  = 1'b0;
  assign e_tag[MT_ZERO_REG]   = '0;
  assign e_ready[MT_ZERO_REG] = 1'b0;

  for (genvar r = 1; r < REG_LEN; r++) begin : g_entry
    map_table_entry #(
      .TW  (TW),
      .RW  (RW),
      .IDX (r)
    ) u_entry (
      .clock             (clock),
      .reset             (reset),
      .stall             (stall),
      .squash            (squash),
      .dispatch_valid    (dispatch_valid),
      .dispatch_dest_idx (dispatch_dest_idx),
      .dispatch_tag      (dispatch_tag),
      .cdb_valid         (cdb_valid),
      .cdb_tag           (cdb_tag),
      .retire_valid      (retire_valid),
      .retire_tag        (retire_tag),
      .retire_dest_idx   (retire_dest_idx),
      .busy              (e_busy[r]),
      .tag               (e_tag[r]),
      .ready             (e_ready[r])
    );
  end

  always_comb begin
    busy_vec = '0;
    for (int r = 0; r < REG_LEN; r++) begin
      busy_vec[r] = e_busy[r];
    end
  end

  // Lookups read registered state only, so a same-cycle dispatch to a
  // source register is not visible (sources are read before the rename).
  // A same-cycle CDB hit is forwarded so the consumer need not wait a cycle.
  always_comb begin
    rs1_busy  = e_busy[rs1_idx];
    rs1_tag   = e_busy[rs1_idx] ? e_tag[rs1_idx] : '0;
    rs1_ready = e_busy[rs1_idx] &
                (e_ready[rs1_idx] | (cdb_valid && (cdb_tag == e_tag[rs1_idx])));
    rs2_busy  = e_busy[rs2_idx];
    rs2_tag   = e_busy[rs2_idx] ? e_tag[rs2_idx] : '0;
    rs2_ready = e_busy[rs2_idx] &
                (e_ready[rs2_idx] | (cdb_valid && (cdb_tag == e_tag[rs2_idx])));
  end

endmodule

// File: tb/tb_map_table.sv
// Self-checking bench for map_table: directed scenarios followed by random
// traffic, compared against an array-based reference model of the table.
module tb_map_table;

  localparam int ROB_LEN = 8;
  localparam int REG_LEN = 32;
  localparam int TW = $clog2(ROB_LEN);
  localparam int RW = $clog2(REG_LEN);

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset, stall, squash;
  logic          dispatch_valid, cdb_valid, retire_valid;
  logic [RW-1:0] dispatch_dest_idx, rs1_idx, rs2_idx, retire_dest_idx;
  logic [TW-1:0] dispatch_tag, cdb_tag, retire_tag;
  logic          rs1_busy, rs2_busy, rs1_ready, rs2_ready;
  logic [TW-1:0] rs1_tag, rs2_tag;
  logic [REG_LEN-1:0] busy_vec;

  map_table #(.ROB_LEN(ROB_LEN), .REG_LEN(REG_LEN)) dut (
    .clock             (clock),
    .reset             (reset),
    .stall             (stall),
    .dispatch_valid    (dispatch_valid),
    .dispatch_dest_idx (dispatch_dest_idx),
    .dispatch_tag      (dispatch_tag),
    .rs1_idx           (rs1_idx),
    .rs2_idx           (rs2_idx),
    .cdb_valid         (cdb_valid),
    .cdb_tag           (cdb_tag),
    .retire_valid      (retire_valid),
    .retire_tag        (retire_tag),
    .retire_dest_idx   (retire_dest_idx),
    .squash            (squash),
    .rs1_busy          (rs1_busy),
    .rs2_busy          (rs2_busy),
    .rs1_tag           (rs1_tag),
    .rs2_tag           (rs2_tag),
    .rs1_ready         (rs1_ready),
    .rs2_ready         (rs2_ready),
    .busy_vec          (busy_vec)
  );

  // ---------------- reference model ----------------
  // Each register either holds "no producer" or the ROB tag of its newest
  // producer plus whether that producer has completed.
  bit       m_busy  [REG_LEN];
  int       m_tag   [REG_LEN];
  bit       m_ready [REG_LEN];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int r = 0; r < REG_LEN; r++) begin
      m_busy[r] = 0; m_tag[r] = 0; m_ready[r] = 0;
    end
  endtask

  // Apply one clock edge worth of the architectural rules to the model.
  task automatic model_update();
    int d, rd;
    d  = int'(dispatch_dest_idx);
    rd = int'(retire_dest_idx);
    if (reset || squash) begin
      model_clear();
      return;
    end
    if (cdb_valid)
      for (int r = 1; r < REG_LEN; r++)
        if (m_busy[r] && m_tag[r] == int'(cdb_tag)) m_ready[r] = 1;
    if (retire_valid && !stall && rd != 0 && m_busy[rd] && m_tag[rd] == int'(retire_tag)) begin
      m_busy[rd] = 0; m_tag[rd] = 0; m_ready[rd] = 0;
    end
    if (dispatch_valid && !stall && d != 0) begin
      m_busy[d] = 1; m_tag[d] = int'(dispatch_tag); m_ready[d] = 0;
    end
  endtask

  task automatic exp_lookup(input int idx, output bit b, output int t, output bit rdy);
    b = 0; t = 0; rdy = 0;
    if (idx != 0 && m_busy[idx]) begin
      b   = 1;
      t   = m_tag[idx];
      rdy = m_ready[idx] || (cdb_valid && int'(cdb_tag) == m_tag[idx]);
    end
  endtask

  task automatic compare_all();
    bit b; int t; bit rdy;
    logic [REG_LEN-1:0] bv;
    exp_lookup(int'(rs1_idx), b, t, rdy);
    check("rs1_busy", 32'(rs1_busy), 32'(b));
    check("rs1_tag", 32'(rs1_tag), 32'(t));
    check("rs1_ready", 32'(rs1_ready), 32'(rdy));
    exp_lookup(int'(rs2_idx), b, t, rdy);
    check("rs2_busy", 32'(rs2_busy), 32'(b));
    check("rs2_tag", 32'(rs2_tag), 32'(t));
    check("rs2_ready", 32'(rs2_ready), 32'(rdy));
    bv = '0;
    for (int r = 0; r < REG_LEN; r++) bv[r] = m_busy[r];
    check("busy_vec", 32'(busy_vec), 32'(bv));
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    reset = 0; stall = 0; squash = 0;
    dispatch_valid = 0; dispatch_dest_idx = '0; dispatch_tag = '0;
    cdb_valid = 0; cdb_tag = '0;
    retire_valid = 0; retire_tag = '0; retire_dest_idx = '0;
  endtask

  task automatic settle();
    @(negedge clock);
    compare_all();
  endtask

  task automatic edge_adv();
    @(posedge clock);
    model_update();
    #1;
  endtask

  task automatic tick();
    settle();
    edge_adv();
  endtask

  task automatic dispatch(input int dest, input int tg);
    idle();
    dispatch_valid = 1; dispatch_dest_idx = RW'(dest); dispatch_tag = TW'(tg);
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle();
    rs1_idx = '0; rs2_idx = '0;
    reset = 1;
    @(posedge clock);
    model_clear();
    #1;
    tick();
    idle();

    // Lookup after reset.
    rs1_idx = 5; rs2_idx = 0;
    settle();
    check("rst_rs1_busy", 32'(rs1_busy), 0);
    check("rst_rs1_tag", 32'(rs1_tag), 0);
    check("rst_rs2_ready", 32'(rs2_ready), 0);
    edge_adv();

    // Dispatch, lookup, CDB forwarding and held ready.
    dispatch(5, 3);
    idle(); rs1_idx = 5;
    settle();
    check("d_rs1_busy", 32'(rs1_busy), 1);
    check("d_rs1_tag", 32'(rs1_tag), 3);
    check("d_rs1_ready", 32'(rs1_ready), 0);
    edge_adv();
    cdb_valid = 1; cdb_tag = 3;
    settle();
    check("fwd_rs1_ready", 32'(rs1_ready), 1);
    edge_adv();
    idle();
    settle();
    check("held_rs1_ready", 32'(rs1_ready), 1);
    edge_adv();

    // Stale retire leaves the newer rename in place.
    dispatch(5, 3);
    dispatch(5, 4);
    idle(); retire_valid = 1; retire_tag = 3; retire_dest_idx = 5;
    tick();
    idle();
    settle();
    check("stale_ret_busy", 32'(rs1_busy), 1);
    check("stale_ret_tag", 32'(rs1_tag), 4);
    edge_adv();
    retire_valid = 1; retire_tag = 4; retire_dest_idx = 5;
    tick();
    idle();
    settle();
    check("ret_busy", 32'(rs1_busy), 0);
    edge_adv();

    // Same-register retire and dispatch: dispatch wins.
    dispatch(7, 2);
    idle();
    retire_valid = 1; retire_tag = 2; retire_dest_idx = 7;
    dispatch_valid = 1; dispatch_dest_idx = 7; dispatch_tag = 6;
    rs2_idx = 7;
    settle();
    check("nofwd_rename_tag", 32'(rs2_tag), 2);
    edge_adv();
    idle();
    settle();
    check("dr_busy", 32'(rs2_busy), 1);
    check("dr_tag", 32'(rs2_tag), 6);
    check("dr_ready", 32'(rs2_ready), 0);
    edge_adv();

    // Squash overrides a same-cycle dispatch.
    for (int r = 1; r <= 4; r++) dispatch(r, r);
    idle(); squash = 1; dispatch_valid = 1; dispatch_dest_idx = 9; dispatch_tag = 5;
    tick();
    idle();
    settle();
    check("squash_busy_vec", 32'(busy_vec), 0);
    edge_adv();

    // Stall blocks dispatch but not CDB.
    dispatch(3, 1);
    idle(); stall = 1; dispatch_valid = 1; dispatch_dest_idx = 8; dispatch_tag = 1;
    cdb_valid = 1; cdb_tag = 1;
    tick();
    idle(); rs1_idx = 3; rs2_idx = 8;
    settle();
    check("stall_r3_ready", 32'(rs1_ready), 1);
    check("stall_r8_busy", 32'(rs2_busy), 0);
    edge_adv();

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      int pick;
      idle();
      stall  = ($urandom_range(0, 4) == 0);
      squash = ($urandom_range(0, 40) == 0);
      reset  = ($urandom_range(0, 80) == 0);
      dispatch_valid    = ($urandom_range(0, 2) != 0);
      dispatch_dest_idx = RW'($urandom_range(0, REG_LEN - 1));
      dispatch_tag      = TW'($urandom_range(0, ROB_LEN - 1));
      cdb_valid = ($urandom_range(0, 1) == 1);
      cdb_tag   = TW'($urandom_range(0, ROB_LEN - 1));
      retire_valid = ($urandom_range(0, 1) == 1);
      pick = $urandom_range(1, REG_LEN - 1);
      retire_dest_idx = RW'(pick);
      // Usually retire the register's current producer so retires land.
      retire_tag = ($urandom_range(0, 3) != 0) ? TW'(m_tag[pick])
                                               : TW'($urandom_range(0, ROB_LEN - 1));
      rs1_idx = ($urandom_range(0, 3) == 0) ? dispatch_dest_idx
                                            : RW'($urandom_range(0, REG_LEN - 1));
      rs2_idx = ($urandom_range(0, 3) == 0) ? retire_dest_idx
                                            : RW'($urandom_range(0, REG_LEN - 1));
      tick();
    end

    idle();
    settle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Guard against a stuck run.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
